program_word_loader: RTL and testbench

- Writer-side counterpart to the program-word fetch path: takes a byte stream (e.g. from a host/UART bridge) and writes BIT_WIDTH-bit program words into the program memory's write port.
- Stream format: 4-byte header (start address, word count, both 16-bit little-endian), then count×BYTES_PER_WORD payload bytes, little-endian per word.
- Sits between the host byte source and the program memory; the fetch side reads what this block writes.

---
 rtl/program_word_loader.sv | 129 ++++++++++++
 tb/tb_program_word_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_word_loader.sv
// Loads program words from a byte stream: 4-byte header (start address, word count,
// both 16-bit little-endian) followed by count little-endian payload words.
module program_word_loader #(
  parameter int BIT_WIDTH = 16,
  parameter int MEM_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 abort,
  output logic                 wr_en,
  output logic [15:0]          wr_addr,
  output logic [BIT_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int BYTES_PER_WORD = BIT_WIDTH / 8;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    HDR_A0, HDR_A1, HDR_C0, HDR_C1, DATA, FINISH
  } state_t;

  state_t               state_reg;
  logic [15:0]          addr_reg;
  logic [15:0]          count_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [BIT_WIDTH-1:0] acc_reg;
  logic [BIT_WIDTH-1:0] word_next;
  logic                 xfer;
  logic                 addr_ok;

  assign xfer    = in_valid & in_ready;
  // 17-bit compare so MEM_WORDS = 65536 accepts every 16-bit address.
  assign addr_ok = {1'b0, addr_reg} < MEM_LIMIT;

  // The word as it looks once the incoming byte is merged into its lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word_next[gi*8 +: 8] = (idx_reg == IDX_W'(gi)) ? in_data : acc_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HDR_A0;
      addr_reg  <= '0;
      count_reg <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wr_en    <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
      if (abort) begin
        state_reg <= HDR_A0;
        busy      <= 1'b0;
        idx_reg   <= '0;
        acc_reg   <= '0;
      end else begin
        case (state_reg)
          HDR_A0: if (xfer) begin
            addr_reg[7:0] <= in_data;
            busy          <= 1'b1;
            state_reg     <= HDR_A1;
          end
          HDR_A1: if (xfer) begin
            addr_reg[15:8] <= in_data;
            state_reg      <= HDR_C0;
          end
          HDR_C0: if (xfer) begin
            count_reg[7:0] <= in_data;
            state_reg      <= HDR_C1;
          end
          HDR_C1: if (xfer) begin
            count_reg[15:8] <= in_data;
            idx_reg         <= '0;
            if ({in_data, count_reg[7:0]} == 16'd0) begin
              state_reg <= FINISH;
              done      <= 1'b1;
              busy      <= 1'b0;
              in_ready  <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end
          DATA: if (xfer) begin
            if (idx_reg == LAST_IDX) begin
              // Address and data update even when the strobe is suppressed.
              wr_en     <= addr_ok;
              wr_addr   <= addr_reg;
              wr_data   <= word_next;
              addr_reg  <= addr_reg + 16'd1;
              count_reg <= count_reg - 16'd1;
              idx_reg   <= '0;
              if (!addr_ok) overflow <= 1'b1;
              if (count_reg == 16'd1) begin
                state_reg <= FINISH;
                done      <= 1'b1;
                busy      <= 1'b0;
                in_ready  <= 1'b0;
              end
            end else begin
              acc_reg <= word_next;
              idx_reg <= idx_reg + 1'b1;
            end
          end
          FINISH:  state_reg <= HDR_A0;
          default: state_reg <= HDR_A0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_word_loader.sv
// Drives one byte stream into two loaders (256-word and 65536-word memories) and
// compares their writes, done timing and overflow with a load-level reference model.
module tb_program_word_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, abort;
  logic [7:0]  in_data;
  logic        in_ready_a, wr_en_a, busy_a, done_a, ovf_a;
  logic [15:0] wr_addr_a, wr_data_a;
  logic        in_ready_b, wr_en_b, busy_b, done_b, ovf_b;
  logic [15:0] wr_addr_b, wr_data_b;

  program_word_loader #(.BIT_WIDTH(16), .MEM_WORDS(256)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .abort(abort), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a));

  program_word_loader #(.BIT_WIDTH(16), .MEM_WORDS(65536)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .abort(abort), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b));

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  bit ovf_exp_a = 0;
  bit ovf_exp_b = 0;
  logic [15:0] pay[$];

  // Monitor-owned observations; the main thread only reads them.
  wr_t obs_a[$];
  wr_t obs_b[$];
  int  done_n_a = 0, done_n_b = 0, done_cyc_a = 0, done_cyc_b = 0;
  int  done_err = 0, irdy_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en_a) obs_a.push_back('{a: wr_addr_a, d: wr_data_a, c: cyc});
    if (wr_en_b) obs_b.push_back('{a: wr_addr_b, d: wr_data_b, c: cyc});
    if (done_a) begin
      done_n_a++;
      done_cyc_a = cyc;
      if (in_ready_a || busy_a) done_err++;
    end
    if (done_b) begin
      done_n_b++;
      done_cyc_b = cyc;
      if (in_ready_b || busy_b) done_err++;
    end
    if (in_ready_a !== in_ready_b) irdy_mis++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap, input bit chk_busy);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("xfer_ready", in_ready_a, 1);
    if (chk_busy) check("busy_mid", busy_a, 1);
    xfer_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("rst_irdy", in_ready_a, 0);
    check("rst_wr_en", wr_en_a | wr_en_b, 0);
    check("rst_addr", wr_addr_a | wr_addr_b, 0);
    check("rst_data", wr_data_a | wr_data_b, 0);
    check("rst_busy", busy_a | busy_b, 0);
    check("rst_done", done_a | done_b, 0);
    check("rst_ovf", ovf_a | ovf_b, 0);
    rst = 1'b0;
    ovf_exp_a = 0;
    ovf_exp_b = 0;
    @(negedge clk);
    check("post_rst_irdy", in_ready_a, 1);
  endtask

  // Expected behaviour of a whole load: word i goes to (start+i) mod 2^16 unless that is out of range.
  task automatic check_side(input string s, input wr_t q[$], input int base, input int dn,
                            input int dcyc, input logic [15:0] waddr, input logic [15:0] wdata,
                            input logic ovf, input int mem, input logic [15:0] start,
                            input logic [15:0] words[$], inout bit ovf_exp);
    int cnt = words.size();
    wr_t e[$];
    logic [15:0] a;
    for (int i = 0; i < cnt; i++) begin
      a = start + 16'(i);
      if (int'(a) < mem) e.push_back('{a: a, d: words[i], c: 0});
      else ovf_exp = 1;
    end
    check({s, "_nwr"}, q.size() - base, e.size());
    for (int i = 0; i < e.size() && base + i < q.size(); i++) begin
      check({s, "_wr_addr"}, q[base+i].a, e[i].a);
      check({s, "_wr_data"}, q[base+i].d, e[i].d);
    end
    check({s, "_ndone"}, dn, 1);
    check({s, "_done_cyc"}, dcyc, xfer_cyc + 1);
    if (cnt > 0) begin
      a = start + 16'(cnt - 1);
      check({s, "_addr_hold"}, waddr, a);
      check({s, "_data_hold"}, wdata, words[cnt-1]);
      if (int'(a) < mem && q.size() > base) check({s, "_last_wr_cyc"}, q[q.size()-1].c, dcyc);
    end
    check({s, "_ovf"}, ovf, ovf_exp);
  endtask

  task automatic run_load(input logic [15:0] start, input int cnt, input int mode);
    logic [15:0] words[$];
    logic [7:0]  bytes[$];
    int base_a, base_b, dn_a, dn_b, gap;
    for (int i = 0; i < cnt; i++) words.push_back(i < pay.size() ? pay[i] : 16'($urandom));
    pay.delete();
    bytes = '{start[7:0], start[15:8], 8'(cnt), 8'(cnt >> 8)};
    foreach (words[i]) begin
      bytes.push_back(words[i][7:0]);
      bytes.push_back(words[i][15:8]);
    end
    base_a = obs_a.size(); base_b = obs_b.size();
    dn_a = done_n_a; dn_b = done_n_b;
    foreach (bytes[i]) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? int'($urandom_range(0, 2)) : (i > 0 ? 1 : 0);
      put_byte(bytes[i], gap, i > 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("after_busy", busy_a, 0);
    check("after_irdy", in_ready_a, 1);
    check_side("A", obs_a, base_a, done_n_a - dn_a, done_cyc_a, wr_addr_a, wr_data_a, ovf_a,
               256, start, words, ovf_exp_a);
    check_side("B", obs_b, base_b, done_n_b - dn_b, done_cyc_b, wr_addr_b, wr_data_b, ovf_b,
               65536, start, words, ovf_exp_b);
    $display("load start=%04h count=%0d mode=%0d writes_a=%0d writes_b=%0d",
             start, cnt, mode, obs_a.size() - base_a, obs_b.size() - base_b);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base_a, base_b, dn_a, dn_b;
    logic [15:0] st;
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = 8'h00;
    do_reset();

    pay = '{16'h1234, 16'h5678};
    run_load(16'h0010, 2, 0);
    run_load(16'h0005, 0, 0);
    run_load(16'h00FF, 2, 0);
    run_load(16'hFFFF, 2, 0);
    pay = '{16'h1234, 16'h5678};
    run_load(16'h0010, 2, 2);

    // Abort after one payload byte, then reset in the middle of the next header.
    base_a = obs_a.size(); base_b = obs_b.size();
    dn_a = done_n_a; dn_b = done_n_b;
    put_byte(8'h20, 0, 0);
    put_byte(8'h00, 0, 1);
    put_byte(8'h02, 0, 1);
    put_byte(8'h00, 0, 1);
    put_byte(8'h11, 0, 1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hAA; abort = 1'b1;
    check("abort_busy_before", busy_a, 1);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy_after", busy_a | busy_b, 0);
    check("abort_irdy", in_ready_a, 1);
    repeat (3) @(negedge clk);
    put_byte(8'h30, 0, 0);
    put_byte(8'h00, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hdr_busy", busy_a, 1);
    check("ovf_before_rst", ovf_a, 1);
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_no_wr", (obs_a.size() - base_a) + (obs_b.size() - base_b), 0);
    check("abort_no_done", (done_n_a - dn_a) + (done_n_b - dn_b), 0);
    $display("abort/reset sequence checked");
    run_load(16'h0040, 2, 0);

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 3))
        0: st = 16'($urandom_range(0, 255));
        1: st = 16'($urandom_range(16'h00FC, 16'h0101));
        2: st = 16'($urandom_range(16'hFFFC, 16'hFFFF));
        default: st = 16'($urandom);
      endcase
      run_load(st, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    end

    check("done_cycle_outputs", done_err, 0);
    check("in_ready_agree", irdy_mis, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
